// File: rtl/n_bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the counter-width helper.
package n_bit_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/n_bit_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// Optional macro: SUB_BORROW_OUT_EN adds the final-borrow signal bout.
interface n_bit_serial_subtractor_if #(
  parameter int n = 8
);
  logic         start;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         busy;
  logic         done;
  logic [n-1:0] d;
`ifdef SUB_BORROW_OUT_EN
  logic         bout;
`endif

  modport master (
    output start, a, b,
    input  busy, done, d
`ifdef SUB_BORROW_OUT_EN
    , input bout
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, d
`ifdef SUB_BORROW_OUT_EN
    , output bout
`endif
  );
endinterface

// File: rtl/n_bit_serial_subtractor_bfs.sv
// One-bit full subtractor: diff = x - y - bin, with borrow out.
module n_bit_serial_subtractor_bfs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial n-bit subtractor, d = a - b mod 2^n, one bit per clock LSB first.
// Optional macro: SUB_BORROW_OUT_EN exposes the final borrow (unsigned a < b).
module n_bit_serial_subtractor
  import n_bit_serial_subtractor_pkg::*;
#(
  parameter int n = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  n_bit_serial_subtractor_if.slave   bus
);
  localparam int cnt_w = clog2(n);

  state_t           state, state_nxt;
  logic [cnt_w-1:0] cnt;
  logic [n-1:0]     a_sr, b_sr;
  // Only the upper n-1 result bits need storage: the final bit goes
  // straight from the subtractor cell into d on the completing edge.
  logic [n-2:0]     r_sr;
  logic [n-1:0]     r_nxt;
  logic [n-1:0]     d_q;
  logic             br, diff, bit_borrow, last, load;
`ifdef SUB_BORROW_OUT_EN
  logic             bout_q;
`endif

  n_bit_serial_subtractor_bfs u_bfs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (br),
    .diff (diff),
    .bout (bit_borrow)
  );

  assign r_nxt = {diff, r_sr};
  assign last  = (cnt == cnt_w'(n - 1));
  // start is honoured in IDLE and in DONE (back-to-back), never while busy.
  assign load  = bus.start && (state != ST_SHIFT);

  // Next-state logic of the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)      state_nxt = ST_DONE;
      ST_DONE:  state_nxt = bus.start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Operand/result shifters, borrow flop, bit counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are plain registers rather than a RAM, so resetting them is cheap and keeps d at 0 after an abort.
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
`ifdef SUB_BORROW_OUT_EN
      bout_q <= 1'b0;
`endif
    end else if (load) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_nxt[n-1:1];
      br   <= bit_borrow;
      cnt  <= cnt + 1'b1;
      if (last) begin
        d_q    <= r_nxt;
`ifdef SUB_BORROW_OUT_EN
        bout_q <= bit_borrow;
`endif
      end
    end
  end

  assign bus.busy = (state == ST_SHIFT);
  assign bus.done = (state == ST_DONE);
  assign bus.d    = d_q;
`ifdef SUB_BORROW_OUT_EN
  assign bus.bout = bout_q;
`endif

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Self-checking bench for n_bit_serial_subtractor (n=8 and n=4 instances).
// Checks bout only when SUB_BORROW_OUT_EN is defined.
module tb_n_bit_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  n_bit_serial_subtractor_if #(.n(8)) if8 ();
  n_bit_serial_subtractor_if #(.n(4)) if4 ();

  n_bit_serial_subtractor #(.n(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  n_bit_serial_subtractor #(.n(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;

  // Reference model: plain modular arithmetic on the masked operands.
  function automatic logic [7:0] ref_diff(input int w, input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] m;
    m = (9'd1 << w) - 9'd1;
    return 8'((int'(av & m[7:0]) - int'(bv & m[7:0])) & int'(m));
  endfunction

  function automatic logic ref_borrow(input int w, input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] m;
    m = (9'd1 << w) - 9'd1;
    return (av & m[7:0]) < (bv & m[7:0]);
  endfunction

  task automatic drive(input bit use4, input bit s, input logic [7:0] av, input logic [7:0] bv);
    if (use4) begin
      if4.start = s; if4.a = av[3:0]; if4.b = bv[3:0];
    end else begin
      if8.start = s; if8.a = av;      if8.b = bv;
    end
  endtask

  // One operation: start for one cycle (or held while busy), operands
  // scrambled after acceptance; observes busy count, latency in edges
  // after the accept edge, number of done pulses, and the result.
  task automatic run_op(input bit use4, input logic [7:0] av, input logic [7:0] bv, input bit hold,
                        output logic [7:0] dq, output logic bq,
                        output int busy_n, output int lat, output int dones);
    int nb;
    nb = use4 ? 4 : 8;
    dq = 'x; bq = 1'bx; busy_n = 0; lat = -1; dones = 0;
    @(negedge clk);
    drive(use4, 1'b1, av, bv);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      drive(use4, hold && (c < nb), 8'($urandom), 8'($urandom));
      if (use4 ? if4.busy : if8.busy) busy_n++;
      if (use4 ? if4.done : if8.done) begin
        dones++;
        if (lat < 0) begin
          lat = c - 1;
          dq  = use4 ? {4'h0, if4.d} : if8.d;
`ifdef SUB_BORROW_OUT_EN
          bq  = use4 ? if4.bout : if8.bout;
`else
          bq  = 1'b0;
`endif
        end
      end
      if (lat >= 0 && c > lat + 1) break;
    end
    drive(use4, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({if8.busy, if8.done, if8.d} !== 10'h000) $display("FAIL reset8 busy/done/d got %b/%b/%h want 0/0/00", if8.busy, if8.done, if8.d);
    else passed++;
    checks++;
    if ({if4.busy, if4.done, if4.d} !== 6'h00) $display("FAIL reset4 busy/done/d got %b/%b/%h want 0/0/0", if4.busy, if4.done, if4.d);
    else passed++;
`ifdef SUB_BORROW_OUT_EN
    checks++;
    if ({if8.bout, if4.bout} !== 2'b00) $display("FAIL reset_bout got %b%b want 00", if8.bout, if4.bout);
    else passed++;
`endif
    rst = 1'b0;
  endtask

  // Directed single operation with full protocol and result checks.
  task automatic directed(input string name, input bit use4, input logic [7:0] av, input logic [7:0] bv, input bit hold);
    logic [7:0] dq, exp_d;
    logic       bq;
    int         busy_n, lat, dones, nb;
    nb    = use4 ? 4 : 8;
    exp_d = ref_diff(nb, av, bv);
    run_op(use4, av, bv, hold, dq, bq, busy_n, lat, dones);
    checks++;
    if (dq !== exp_d) $display("FAIL %s d got %h want %h", name, dq, exp_d);
    else passed++;
    checks++;
    if (busy_n !== nb || lat !== nb || dones !== 1)
      $display("FAIL %s protocol busy/lat/dones got %0d/%0d/%0d want %0d/%0d/1", name, busy_n, lat, dones, nb, nb);
    else passed++;
`ifdef SUB_BORROW_OUT_EN
    checks++;
    if (bq !== ref_borrow(nb, av, bv)) $display("FAIL %s bout got %b want %b", name, bq, ref_borrow(nb, av, bv));
    else passed++;
`endif
  endtask

  task automatic test_basic();
    directed("sub_5a_23", 1'b0, 8'h5A, 8'h23, 1'b0);
  endtask

  task automatic test_boundary();
    directed("sub_00_01", 1'b0, 8'h00, 8'h01, 1'b0);
    directed("sub_80_80", 1'b0, 8'h80, 8'h80, 1'b0);
    directed("sub_ff_00", 1'b0, 8'hFF, 8'h00, 1'b0);
  endtask

  task automatic test_start_ignored();
    directed("start_held", 1'b0, 8'hC3, 8'h3C, 1'b1);
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hF0, 8'h0F);
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({if8.busy, if8.done, if8.d} !== 10'h000) $display("FAIL reset_mid busy/done/d got %b/%b/%h want 0/0/00", if8.busy, if8.done, if8.d);
    else passed++;
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if8.done || if8.busy) dones++;
    end
    checks++;
    if (dones !== 0 || if8.d !== 8'h00) $display("FAIL reset_mid_aborted activity/d got %0d/%h want 0/00", dones, if8.d);
    else passed++;
    directed("after_reset", 1'b0, 8'h21, 8'h43, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h5A, 8'h23);
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      if (if8.done) begin lat = c - 1; break; end
    end
    checks++;
    if (lat !== 8 || if8.d !== 8'h37) $display("FAIL b2b_first lat/d got %0d/%h want 8/37", lat, if8.d);
    else passed++;
    drive(1'b0, 1'b1, 8'h10, 8'h20);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'hAA, 8'h55);
    checks++;
    if ({if8.busy, if8.done, if8.d} !== {2'b10, 8'h37}) $display("FAIL b2b_no_gap busy/done/d got %b/%b/%h want 1/0/37", if8.busy, if8.done, if8.d);
    else passed++;
    lat2 = -1;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (if8.done) begin lat2 = c - 1; break; end
    end
    checks++;
    if (lat2 !== 8 || if8.d !== 8'hF0) $display("FAIL b2b_second lat/d got %0d/%h want 8/f0", lat2, if8.d);
    else passed++;
`ifdef SUB_BORROW_OUT_EN
    checks++;
    if (if8.bout !== 1'b1) $display("FAIL b2b_bout got %b want 1", if8.bout);
    else passed++;
`endif
  endtask

  task automatic test_n4();
    directed("n4_3_5", 1'b1, 8'h03, 8'h05, 1'b0);
    directed("n4_f_f", 1'b1, 8'h0F, 8'h0F, 1'b0);
  endtask

  task automatic test_random(input bit use4, input int ops);
    logic [7:0] av, bv, dq, exp_d;
    logic       bq;
    int         busy_n, lat, dones, nb;
    nb = use4 ? 4 : 8;
    for (int i = 0; i < ops; i++) begin
      av    = 8'($urandom);
      bv    = 8'($urandom);
      exp_d = ref_diff(nb, av, bv);
      run_op(use4, av, bv, 1'b0, dq, bq, busy_n, lat, dones);
      checks++;
      if (dq !== exp_d || busy_n !== nb || lat !== nb || dones !== 1)
        $display("FAIL rand_n%0d a=%h b=%h d/busy/lat/dones got %h/%0d/%0d/%0d want %h/%0d/%0d/1",
                 nb, av, bv, dq, busy_n, lat, dones, exp_d, nb, nb);
      else passed++;
`ifdef SUB_BORROW_OUT_EN
      checks++;
      if (bq !== ref_borrow(nb, av, bv)) $display("FAIL rand_n%0d_bout a=%h b=%h got %b want %b", nb, av, bv, bq, ref_borrow(nb, av, bv));
      else passed++;
`endif
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout after %0d/%0d checks", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_n4();
    test_random(1'b0, 1000);
    test_random(1'b1, 300);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
